// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
// Holds the controller state encoding, the fixed word/line geometry and
// helpers that derive index and tag widths from the number of lines.
package dcache_pkg;

  localparam int ADDR_BITS   = 32;
  localparam int WORD_BITS   = 32;
  localparam int LINE_BITS   = 128;
  localparam int OFFSET_BITS = 4;

  // Controller states, kept as plain constants so older tools can read them.
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_ALLOCATE  = 2'd2;

  function automatic int index_bits(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_bits(input int num_lines);
    return ADDR_BITS - OFFSET_BITS - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Storage for the data cache: per-line valid, dirty, tag and data.
// Ports:
//   clk_i, rst_i        clock and synchronous active-high reset
//   rd_idx_i            asynchronous read index
//   rd_valid_o/_dirty_o line status at rd_idx_i
//   rd_tag_o, rd_data_o tag and line data at rd_idx_i
//   wr_en_i, wr_idx_i   write strobe and line index
//   wr_mask_i           per-word write enables for the data
//   wr_data_i           line-wide write data (masked by wr_mask_i)
//   wr_tag_i, wr_dirty_i tag and dirty value stored on every write
// Only valid/dirty are reset; tag and data contents are don't-care while
// the line is invalid.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = 4,
  parameter int TAG_W     = 24,
  parameter int LINE_W    = 128
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [IDX_W-1:0]            rd_idx_i,
  output logic                        rd_valid_o,
  output logic                        rd_dirty_o,
  output logic [TAG_W-1:0]            rd_tag_o,
  output logic [LINE_W-1:0]           rd_data_o,
  input  logic                        wr_en_i,
  input  logic [IDX_W-1:0]            wr_idx_i,
  input  logic [LINE_W/WORD_BITS-1:0] wr_mask_i,
  input  logic [LINE_W-1:0]           wr_data_i,
  input  logic [TAG_W-1:0]            wr_tag_i,
  input  logic                        wr_dirty_i
);

  localparam int NW = LINE_W / WORD_BITS;

  logic [LINE_W-1:0]    data_q [NUM_LINES];
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int w = 0; w < NW; w++) begin
        if (wr_mask_i[w]) begin
          data_q[wr_idx_i][w*WORD_BITS +: WORD_BITS] <= wr_data_i[w*WORD_BITS +: WORD_BITS];
        end
      end
      tag_q[wr_idx_i] <= wr_tag_i;
    end
  end

  // Any write leaves the line valid: both the fill and a store hit target a
  // line that is (or becomes) resident.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      dirty_q[wr_idx_i] <= wr_dirty_i;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   cpu_req_i       CPU load/store request
//   cpu_we_i        1 = store, 0 = load
//   cpu_addr_i      byte address (bits [1:0] ignored)
//   cpu_wdata_i     store data
//   cpu_rdata_o     load data on a hit, else 0
//   cpu_stall_o     stall the pipeline while a miss is being serviced
//   mem_req_o       registered backing-memory request
//   mem_we_o        1 = line write-back, 0 = line fill
//   mem_addr_o      line-aligned memory address
//   mem_wdata_o     victim line for write-back
//   mem_rdata_i     fill line, valid with mem_ack_i
//   mem_ack_i       one-cycle completion pulse
module dcache_controller #(
  parameter int NUM_LINES = 16,
  parameter int LINE_BITS = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_wdata_i,
  output logic [31:0]          cpu_rdata_o,
  output logic                 cpu_stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_wdata_o,
  input  logic [LINE_BITS-1:0] mem_rdata_i,
  input  logic                 mem_ack_i
);

  import dcache_pkg::*;

  localparam int IDX_W  = index_bits(NUM_LINES);
  localparam int TAG_W  = tag_bits(NUM_LINES);
  localparam int NWORDS = LINE_BITS / WORD_BITS;

  // Address fields
  logic [1:0]       cpu_off;
  logic [IDX_W-1:0] cpu_idx;
  logic [TAG_W-1:0] cpu_tag;
  logic             unused_addr_bits;

  assign cpu_off          = cpu_addr_i[OFFSET_BITS-1:2];
  assign cpu_idx          = cpu_addr_i[OFFSET_BITS +: IDX_W];
  assign cpu_tag          = cpu_addr_i[ADDR_BITS-1 -: TAG_W];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  // Controller state
  state_t               state_q, state_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0] mem_wdata_q, mem_wdata_d;
  // Missing line is captured so the fill completes even if the CPU drops
  // its request mid-miss.
  logic [TAG_W-1:0]     miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]     miss_idx_q, miss_idx_d;

  // Storage interface
  logic                 rd_valid, rd_dirty;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_data;
  logic                 wr_en;
  logic [IDX_W-1:0]     wr_idx;
  logic [NWORDS-1:0]    wr_mask;
  logic [LINE_BITS-1:0] wr_data;
  logic [TAG_W-1:0]     wr_tag;
  logic                 wr_dirty;

  logic                 tag_match;
  logic                 ack;
  logic                 stall;
  logic [31:0]          rdata;

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W),
    .LINE_W    (LINE_BITS)
  ) u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_idx_i   (cpu_idx),
    .rd_valid_o (rd_valid),
    .rd_dirty_o (rd_dirty),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (wr_en),
    .wr_idx_i   (wr_idx),
    .wr_mask_i  (wr_mask),
    .wr_data_i  (wr_data),
    .wr_tag_i   (wr_tag),
    .wr_dirty_i (wr_dirty)
  );

  assign tag_match = rd_valid && (rd_tag == cpu_tag);
  // An ack only counts while a request is outstanding.
  assign ack       = mem_ack_i && mem_req_q;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    miss_tag_d  = miss_tag_q;
    miss_idx_d  = miss_idx_q;
    wr_en       = 1'b0;
    wr_idx      = cpu_idx;
    wr_mask     = '0;
    wr_data     = {NWORDS{cpu_wdata_i}};
    wr_tag      = cpu_tag;
    wr_dirty    = 1'b1;
    stall       = 1'b0;
    rdata       = '0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req_i) begin
          if (tag_match) begin
            if (cpu_we_i) begin
              wr_en   = 1'b1;
              wr_mask = NWORDS'(1) << cpu_off;
            end else begin
              rdata = rd_data[cpu_off*WORD_BITS +: WORD_BITS];
            end
          end else begin
            stall      = 1'b1;
            miss_tag_d = cpu_tag;
            miss_idx_d = cpu_idx;
            mem_req_d  = 1'b1;
            if (rd_valid && rd_dirty) begin
              state_d     = ST_WRITEBACK;
              mem_we_d    = 1'b1;
              mem_addr_d  = {rd_tag, cpu_idx, {OFFSET_BITS{1'b0}}};
              mem_wdata_d = rd_data;
            end else begin
              state_d    = ST_ALLOCATE;
              mem_we_d   = 1'b0;
              mem_addr_d = {cpu_tag, cpu_idx, {OFFSET_BITS{1'b0}}};
            end
          end
        end
      end
      ST_WRITEBACK: begin
        stall = 1'b1;
        // Request stays high; switching to the fill is signalled by mem_we_o.
        if (ack) begin
          state_d    = ST_ALLOCATE;
          mem_we_d   = 1'b0;
          mem_addr_d = {miss_tag_q, miss_idx_q, {OFFSET_BITS{1'b0}}};
        end
      end
      ST_ALLOCATE: begin
        stall = 1'b1;
        if (ack) begin
          wr_en     = 1'b1;
          wr_idx    = miss_idx_q;
          wr_mask   = '1;
          wr_data   = mem_rdata_i;
          wr_tag    = miss_tag_q;
          wr_dirty  = 1'b0;
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // Reset masks the CPU-facing outputs and blocks store-hit writes.
    if (rst_i) begin
      stall = 1'b0;
      rdata = '0;
      wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    miss_tag_q <= miss_tag_d;
    miss_idx_q <= miss_idx_d;
  end

  assign cpu_stall_o = stall;
  assign cpu_rdata_o = rdata;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dcache_controller.sv
module tb_dcache_controller;

  localparam int NL   = 16;
  localparam int IDXW = $clog2(NL);
  localparam int TAGW = 32 - 4 - IDXW;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;

  dcache_controller #(.NUM_LINES(NL), .LINE_BITS(128)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_rdata_o (cpu_rdata),
    .cpu_stall_o (cpu_stall),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // Reference model: cache contents as plain arrays, backing memory as a
  // word-addressed sparse array with a deterministic default pattern.
  bit            mv [NL];
  bit            md [NL];
  bit [TAGW-1:0] mt [NL];
  bit [31:0]     mw [NL][4];
  bit [31:0]     bmem [bit [31:0]];

  function automatic bit [31:0] mem_word(input bit [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  function automatic bit [127:0] model_line(input int idx);
    return {mw[idx][3], mw[idx][2], mw[idx][1], mw[idx][0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One CPU access; the task also plays the backing memory, acking each
  // transaction after the requested number of request-high cycles.
  task automatic access(input bit we, input bit [31:0] addr, input bit [31:0] wd,
                        input int dwb, input int dfill, input bit drop);
    bit [IDXW-1:0] idx;
    bit [TAGW-1:0] tag;
    int            w;
    bit            hit;
    bit            dropx;
    int            exp_stall;
    bit [31:0]     exp_rd;
    bit            q_we[$];
    bit [31:0]     q_addr[$];
    bit [127:0]    q_data[$];
    int            q_dly[$];
    bit [31:0]     la;
    bit [31:0]     va;
    int            stalls;
    int            txn;
    int            cnt;
    bit            finished;

    idx       = addr[4 +: IDXW];
    tag       = addr[31 -: TAGW];
    w         = int'(addr[3:2]);
    hit       = mv[idx] && (mt[idx] == tag);
    dropx     = drop && !hit;
    exp_stall = 0;
    exp_rd    = '0;
    if (!hit) begin
      exp_stall = 1 + dfill;
      if (mv[idx] && md[idx]) begin
        va = {mt[idx], idx, 4'b0};
        exp_stall += dwb;
        q_we.push_back(1'b1); q_addr.push_back(va);
        q_data.push_back(model_line(idx)); q_dly.push_back(dwb);
        for (int k = 0; k < 4; k++) bmem[va + 32'(4*k)] = mw[idx][k];
      end
      la = {tag, idx, 4'b0};
      for (int k = 0; k < 4; k++) mw[idx][k] = mem_word(la + 32'(4*k));
      q_we.push_back(1'b0); q_addr.push_back(la);
      q_data.push_back(model_line(idx)); q_dly.push_back(dfill);
      mv[idx] = 1'b1; md[idx] = 1'b0; mt[idx] = tag;
    end
    if (!dropx) begin
      if (we) begin
        mw[idx][w] = wd;
        md[idx]    = 1'b1;
      end else begin
        exp_rd = mw[idx][w];
      end
    end

    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    stalls = 0; txn = 0; cnt = 0; finished = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (dropx && c == 1) cpu_req = 1'b0;
      #1;
      if (!cpu_stall) begin
        finished = 1'b1;
        chk("rdata", cpu_rdata, exp_rd);
        chk("req_idle", mem_req, 1'b0);
      end else begin
        stalls++;
        if (c == 0) chk("rdata_stall", cpu_rdata, 32'h0);
        if (mem_req) begin
          if (txn >= q_we.size()) begin
            chk("extra_txn", txn, q_we.size() - 1);
          end else begin
            if (cnt == 0) begin
              chk("mem_we", mem_we, q_we[txn]);
              chk("mem_addr", mem_addr, q_addr[txn]);
              if (q_we[txn]) chk("mem_wdata", mem_wdata, q_data[txn]);
            end
            cnt++;
            if (cnt == q_dly[txn]) begin
              mem_ack   = 1'b1;
              mem_rdata = q_we[txn] ? ~q_data[txn] : q_data[txn];
              txn++;
              cnt = 0;
            end
          end
        end
      end
      @(posedge clk);
      @(negedge clk);
      mem_ack = 1'b0;
      if (finished) break;
    end
    ntests++;
    assert (finished) else begin
      nfail++;
      $error("FAIL timeout: access %0h still stalled after 60 cycles", addr);
    end
    cpu_req = 1'b0;
    chk("stall_cycles", stalls, exp_stall);
    chk("txn_count", txn, q_we.size());
  endtask

  initial begin
    // Reset: request held high to show stall/rdata are masked.
    cpu_req = 1'b1; cpu_addr = 32'h40;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_mem_req", mem_req, 1'b0);
    @(negedge clk);
    rst = 1'b0; cpu_req = 1'b0;
    #1;
    chk("post_rst_mem_we", mem_we, 1'b0);
    chk("post_rst_mem_addr", mem_addr, 32'h0);
    chk("post_rst_mem_wdata", mem_wdata, 128'h0);
    chk("post_rst_stall", cpu_stall, 1'b0);
    model_reset();

    // Clean fill then hits.
    bmem[32'h44] = 32'hDEAD_BEEF;
    access(1'b0, 32'h40, 32'h0, 1, 3, 1'b0);
    access(1'b0, 32'h44, 32'h0, 1, 1, 1'b0);
    chk("deadbeef_model", mw[4][1], 32'hDEAD_BEEF);

    // Store hit and read-back.
    access(1'b1, 32'h48, 32'h1234_5678, 1, 1, 1'b0);
    access(1'b0, 32'h48, 32'h0, 1, 1, 1'b0);

    // Dirty conflict: write-back of tag 0 before fill of tag 1.
    access(1'b0, 32'h140, 32'h0, 2, 2, 1'b0);

    // Store miss merges after the fill; later eviction exposes the line.
    access(1'b1, 32'h80, 32'hCAFE_F00D, 1, 2, 1'b0);
    access(1'b0, 32'h80, 32'h0, 1, 1, 1'b0);
    access(1'b0, 32'h84, 32'h0, 1, 1, 1'b0);
    access(1'b0, 32'h8C, 32'h0, 1, 1, 1'b0);
    access(1'b0, 32'h180, 32'h0, 3, 1, 1'b0);

    // Request dropped mid-miss: fill still completes, then a hit.
    access(1'b0, 32'h2C4, 32'h0, 2, 3, 1'b1);
    access(1'b0, 32'h2C4, 32'h0, 1, 1, 1'b0);

    // Reset during ALLOCATE with a late ack.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300;
    #1;
    chk("r40_miss_stall", cpu_stall, 1'b1);
    @(posedge clk); @(negedge clk); #1;
    chk("r40_alloc_req", mem_req, 1'b1);
    chk("r40_alloc_we", mem_we, 1'b0);
    chk("r40_alloc_addr", mem_addr, 32'h300);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("r40_rst_stall", cpu_stall, 1'b0);
    chk("r40_rst_rdata", cpu_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0; cpu_req = 1'b0; mem_ack = 1'b1; mem_rdata = {4{32'h5555_AAAA}};
    #1;
    chk("r40_req_after_rst", mem_req, 1'b0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("r40_req_after_ack", mem_req, 1'b0);
    chk("r40_stall_idle", cpu_stall, 1'b0);
    model_reset();
    access(1'b0, 32'h300, 32'h0, 1, 2, 1'b0);
    access(1'b0, 32'h44, 32'h0, 1, 1, 1'b0);

    // Randomised traffic over a few tags per index to force conflicts.
    for (int n = 0; n < 80; n++) begin
      bit [31:0] a;
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, NL - 1)) << 4)
        | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 4),
             $urandom_range(1, 4), ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 Parameter: NUM_LINES, 16, number of direct-mapped cache lines (power of two, 4..64).
REQ-002 Parameter: LINE_BITS, 128, line width; four 32-bit words per line.
REQ-003 Port: clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_i  in  1  reset, synchronous, active-high.
REQ-005 Port: cpu_req_i  in  1  CPU data access request (MemRead or MemWrite from EX/MEM stage).
REQ-006 Port: cpu_we_i  in  1  1 = store, 0 = load; valid with cpu_req_i.
REQ-007 Port: cpu_addr_i  in  32  byte address; bits [1:0] ignored.
REQ-008 Port: cpu_wdata_i  in  32  store data.
REQ-009 Port: cpu_rdata_o  out  32  load data; valid when cpu_req_i=1, cpu_we_i=0, cpu_stall_o=0.
REQ-010 Port: cpu_stall_o  out  1  pipeline stall; CPU holds request fields stable while high.
REQ-011 Port: mem_req_o  out  1  backing-memory request, registered.
REQ-012 Port: mem_we_o  out  1  1 = line write-back, 0 = line fill.
REQ-013 Port: mem_addr_o  out  32  line-aligned address, bits [3:0]=0.
REQ-014 Port: mem_wdata_o  out  LINE_BITS  victim line data.
REQ-015 Port: mem_rdata_i  in  LINE_BITS  fill data; valid with mem_ack_i.
REQ-016 Port: mem_ack_i  in  1  single-cycle completion pulse from backing memory.

Function
REQ-017 Address split: offset [3:2] word select, index [3+log2(NUM_LINES):4], tag the remaining upper bits.
REQ-018 States: IDLE, WRITEBACK, ALLOCATE; per-line valid, dirty, tag, data.
REQ-019 IDLE hit (cpu_req_i, valid, tag match): cpu_stall_o=0 combinationally; load returns the selected word in the same cycle.
REQ-020 IDLE store hit: the selected word is updated and dirty set at the next edge; the other three words are unchanged.
REQ-021 IDLE miss: cpu_stall_o=1 in the same cycle; next state is WRITEBACK if the victim is valid and dirty, else ALLOCATE.
REQ-022 WRITEBACK: mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag,index,4'b0}, mem_wdata_o=victim line, all held until mem_ack_i; then go to ALLOCATE.
REQ-023 ALLOCATE: mem_req_o=1, mem_we_o=0, mem_addr_o={cpu tag,index,4'b0} until mem_ack_i; on ack, write mem_rdata_i to the line, set valid=1, dirty=0, tag=cpu tag, and return to IDLE.
REQ-024 After a fill, the IDLE re-compare hits, so a store miss merges its word on that hit cycle and sets dirty.
REQ-025 cpu_stall_o=1 in every WRITEBACK and ALLOCATE cycle.
REQ-026 Latency: a clean miss stalls (ack delay + 1) cycles; a dirty miss adds the write-back ack delay.
REQ-027 mem_ack_i is ignored while mem_req_o=0; mem_req_o deasserts on the edge after ack.
REQ-028 If cpu_req_i drops mid-miss, the transaction still completes (no abort); the controller then idles.
REQ-029 cpu_rdata_o=0 when no load hit is in progress.

Reset
REQ-030 When rst_i=1 at an edge: state=IDLE, all valid and dirty bits clear, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-031 While rst_i=1: cpu_stall_o=0, cpu_rdata_o=0.
REQ-032 Reset during WRITEBACK or ALLOCATE abandons the transaction; a pending mem_ack_i after reset is ignored per REQ-027.
REQ-033 Data and tag arrays are not required to clear on reset.

Structure
REQ-034 Package dcache_pkg holds the state enumeration, WORD_BITS=32, LINE_BITS, OFFSET_BITS=4, and tag/index width functions.
REQ-035 Sub-module dcache_sram holds the tag, valid, dirty, and data arrays, with one read port (asynchronous) and one write port (line or word-masked); the FSM stays in dcache_controller.

Verification
REQ-036 Reset, then load 0x0000_0040 with ack after 3 cycles returning line word1=0xDEADBEEF at addr 0x44 -> stall for 4 cycles, mem_addr_o=0x40, mem_we_o=0; a subsequent load of 0x44 hits with no stall, rdata=0xDEADBEEF.
REQ-037 Store 0x1234_5678 to 0x48 on a hit -> no stall, no mem_req_o; a later load of 0x48 returns 0x12345678.
REQ-038 Dirty line at index 4 (tag A), load with the same index and tag B -> WRITEBACK to {A,index 4,0} with the stored word, then ALLOCATE to {B,index 4,0}; order checked.
REQ-039 Store miss to 0x80 with 0xCAFEF00D -> fill, then merge; the line is dirty and word0=0xCAFEF00D while the other words equal the fill data.
REQ-040 Assert rst_i during ALLOCATE, then pulse mem_ack_i one cycle later -> state IDLE, mem_req_o=0, and the line at that index is invalid (the next access misses).
